// File: rtl/aes_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module : aes_vector_sequencer
// Drives AES_top from a loadable vector buffer and scores results on-chip.
// Rev    : 1.0  initial release
// ============================================================================
module aes_vector_sequencer #(
   parameter int  DATA_W  = 128,
   parameter int  DEPTH   = 8,
   parameter int  TIMEOUT = 64,
   parameter int  GAP     = 2,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              AES_clk,
   input  logic              AES_rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_pt,
   input  logic [DATA_W-1:0] load_key,
   input  logic [DATA_W-1:0] load_exp,
   input  logic              clear,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              AES_en,
   output logic [DATA_W-1:0] AES_data_in,
   output logic [DATA_W-1:0] AES_key_in,
   input  logic [DATA_W-1:0] AES_data_out,
   input  logic              AES_data_out_valid,
   output logic [CNT_W-1:0]  pass_count,
   output logic [CNT_W-1:0]  fail_count,
   output logic [IDX_W-1:0]  first_fail_idx,
   output logic              timeout_flag,
   output logic              spurious_flag
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  c_gap_last  = GAP_W'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_pt  [DEPTH];
   logic [DATA_W-1:0] r_key [DEPTH];
   logic [DATA_W-1:0] r_exp [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [IDX_W-1:0]  r_idx;
   logic [WAIT_W-1:0] r_wait;
   logic [GAP_W-1:0]  r_gap;

   logic              w_start;
   logic              w_load;
   logic              w_timeout;
   logic              w_gap_end;
   logic              w_last;
   logic              w_score;
   logic              w_fail;
   logic              w_enter_run;
   logic [IDX_W-1:0]  w_run_idx;

   assign load_ready  = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH));
   assign w_start     = (r_state == S_IDLE) && start;
   assign w_load      = load_valid && load_ready && !start && !clear;
   assign w_timeout   = (r_state == S_RUN) && !AES_data_out_valid && (r_wait == c_wait_last);
   assign w_gap_end   = (r_state == S_GAP) && (r_gap == c_gap_last);
   assign w_last      = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));
   // A valid on the timeout cycle is scored as a normal compare.
   assign w_score     = (r_state == S_RUN) && (AES_data_out_valid || w_timeout);
   assign w_fail      = w_score && !(AES_data_out_valid && (AES_data_out == r_exp[r_idx]));
   assign w_enter_run = (w_next == S_RUN) && (r_state != S_RUN);
   assign w_run_idx   = (r_state == S_IDLE) ? '0 : r_idx + IDX_W'(1);

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (r_count == '0) ? S_DONE : S_RUN;
         S_RUN:   if (w_score) w_next = S_GAP;
         S_GAP:   if (w_gap_end) w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Vector storage has no reset; contents are only meaningful below r_count.
   always_ff @(posedge AES_clk) begin
      if (w_load) begin
         r_pt[r_count[IDX_W-1:0]]  <= load_pt;
         r_key[r_count[IDX_W-1:0]] <= load_key;
         r_exp[r_count[IDX_W-1:0]] <= load_exp;
      end
   end

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         r_count        <= '0;
         r_idx          <= '0;
         r_wait         <= '0;
         r_gap          <= '0;
         AES_en         <= 1'b0;
         AES_data_in    <= '0;
         AES_key_in     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass_count     <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
         timeout_flag   <= 1'b0;
         spurious_flag  <= 1'b0;
      end else begin
         AES_en <= (w_next == S_RUN);
         busy   <= (w_next == S_RUN) || (w_next == S_GAP);
         done   <= (w_next == S_DONE);
         r_gap  <= (r_state == S_GAP) ? r_gap + GAP_W'(1) : '0;

         if ((r_state == S_IDLE) && clear && !start) begin
            r_count <= '0;
         end else if (w_load) begin
            r_count <= r_count + CNT_W'(1);
         end

         if (w_start) begin
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout_flag   <= 1'b0;
            spurious_flag  <= 1'b0;
         end

         if (w_enter_run) begin
            r_idx       <= w_run_idx;
            r_wait      <= '0;
            AES_data_in <= r_pt[w_run_idx];
            AES_key_in  <= r_key[w_run_idx];
         end else if (r_state == S_RUN) begin
            r_wait <= r_wait + WAIT_W'(1);
         end

         if (w_score) begin
            if (w_fail) begin
               fail_count <= fail_count + CNT_W'(1);
               if (fail_count == '0) first_fail_idx <= r_idx;
            end else begin
               pass_count <= pass_count + CNT_W'(1);
            end
            if (w_timeout) timeout_flag <= 1'b1;
         end

         if (AES_data_out_valid && (r_state != S_RUN)) spurious_flag <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/aes_vector_sequencer.md
# aes_vector_sequencer

Synthesizable, parametrised stimulus/checker that drives the AES_top core with a buffered list of (plaintext, key, expected ciphertext) vectors and scores the results on-chip. It replaces hand-timed enable/data sequences with a loadable vector buffer, per-vector timeout, configurable inter-vector gap and pass/fail accounting. It sits directly in front of AES_top, on the same clock, and is used both in simulation and in FPGA bring-up.

## Interface
- DATA_W, 128, width of plaintext, key and ciphertext
- DEPTH, 8, vector buffer entries (≥1)
- TIMEOUT, 64, max cycles to wait for AES_data_out_valid per vector (≥2)
- GAP, 2, cycles AES_en is held low between vectors (≥1)
- AES_clk  in  1  single clock, all logic rising-edge
- AES_rst  in  1  asynchronous, active-high reset
- load_valid  in  1  vector write request
- load_ready  out  1  high in IDLE while count < DEPTH
- load_pt / load_key / load_exp  in  DATA_W each  vector fields
- clear  in  1  empties buffer (IDLE only)
- start  in  1  run all buffered vectors
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse at end of run
- AES_en  out  1  enable to AES_top
- AES_data_in / AES_key_in  out  DATA_W  to AES_top
- AES_data_out  in  DATA_W  from AES_top
- AES_data_out_valid  in  1  from AES_top
- pass_count / fail_count  out  $clog2(DEPTH+1)  results of last run
- first_fail_idx  out  $clog2(DEPTH) (min 1)  index of first failing vector
- timeout_flag  out  1  sticky: any vector timed out in last run
- spurious_flag  out  1  sticky: valid seen while not waiting

## Operation
- Reset: state IDLE, count 0, all outputs 0 (load_ready then rises to 1 combinationally in IDLE); buffer contents don't-care.
- Load: load_valid && load_ready writes entry[count], count++. Ignored outside IDLE or when full. clear in IDLE sets count 0; clear has priority over load in the same cycle.
- States: IDLE → RUN → GAP → (RUN | DONE) → IDLE.
- IDLE: start with count>0 → RUN, idx=0, clears pass/fail counts, flags, first_fail_idx. start with count==0 → DONE (zero counts). start has priority over load in the same cycle (load not accepted).
- RUN: AES_en=1, AES_data_in=entry[idx].pt, AES_key_in=entry[idx].key, held stable; wait counter increments each cycle.
  - valid: compare AES_data_out with entry[idx].exp; equal → pass_count++, else fail_count++ and, if first failure, first_fail_idx=idx. → GAP.
  - wait counter reaches TIMEOUT with no valid: fail_count++, timeout_flag=1, first-fail capture as above → GAP.
- GAP: AES_en=0 for exactly GAP cycles, data/key hold last values; then idx==count-1 → DONE, else idx++ → RUN.
- DONE: done=1 for one cycle, → IDLE. Buffer and count retained; next start reruns same vectors.
- AES_data_out_valid outside RUN sets spurious_flag; never scored.
- pass_count + fail_count == count after every completed run.
- Reset mid-run: immediate return to reset values; no done pulse.

## Timing
- All outputs registered except load_ready (decoded from state and count).
- start sampled at edge t → busy and AES_en high from t+1.
- valid sampled at edge v → counts update and AES_en low from v+1; next AES_en high from v+1+GAP.
- Timeout: AES_en high for TIMEOUT cycles, low from the following cycle.
- Last vector: done high during cycle v+1+GAP; busy low in that same cycle.
- Valid coinciding with the timeout cycle counts as valid (compare wins).

## Test plan
- FIPS-197 vector (key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, exp 69c4e0d86a7b0430d8cdb78070b4c55a) on real AES_top → pass_count=1, fail_count=0, done pulses once, flags 0.
- Load 3 vectors, vector 1 with exp corrupted (LSB flipped) → pass_count=2, fail_count=1, first_fail_idx=1; AES_en low for exactly GAP cycles between vectors.
- Stub DUT never asserts valid, TIMEOUT=8 → AES_en high 8 cycles, fail_count=1, timeout_flag=1; stub valid on cycle 8 → counted as pass.
- Load DEPTH+2 vectors → load_ready low after DEPTH accepts, count=DEPTH; clear then start with count 0 → done next cycle, counts 0.
- Stub pulses valid during GAP and IDLE → spurious_flag=1, pass/fail unchanged.
- Assert AES_rst mid-RUN on vector 2 → AES_en, busy, counts, flags 0 immediately; load_ready=1; no done pulse.
